// File: rtl/odd_parity_frame_rx.sv
// Odd-parity frame receiver: start, DATA_W data bits LSB first, odd parity, stop.
// Advances one line bit per bit_valid strobe and reports word/status as one-cycle pulses.
module odd_parity_frame_rx #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 rx_bit,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0]    shreg, shreg_n;
  logic                 par, par_n;
  logic                 ok, ok_n;
  logic [DATA_W-1:0]    data_out_n;
  logic                 data_valid_n;
  logic                 parity_err_n;
  logic                 frame_err_n;
  logic [ERR_CNT_W-1:0] err_count_n;

  // State and output registers; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      ok         <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      ok         <= ok_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
      err_count  <= err_count_n;
    end
  end

  // Next-state and output decode; pulses default low so they last one cycle
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shreg_n      = shreg;
    par_n        = par;
    ok_n         = ok;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;
    err_count_n  = err_count;

    if (bit_valid) begin
      case (state)
        ST_IDLE: begin
          if (!rx_bit) begin
            state_n = ST_DATA;
            cnt_n   = '0;
            par_n   = 1'b0;
          end
        end
        ST_DATA: begin
          shreg_n[cnt] = rx_bit;
          par_n        = par ^ rx_bit;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt_n   = '0;
            state_n = ST_PARITY;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          // odd parity holds when data plus parity bit carry an odd number of ones
          ok_n    = par ^ rx_bit;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          if (rx_bit) begin
            data_out_n   = shreg;
            data_valid_n = 1'b1;
            parity_err_n = ~ok;
          end else begin
            frame_err_n = 1'b1;
          end
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // saturating error count, bumped on the same edge that raises an error pulse
    if ((parity_err_n || frame_err_n) && (err_count != '1)) begin
      err_count_n = err_count + ERR_CNT_W'(1);
    end
  end

  // Frame-in-progress flag decoded straight from the state register
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_odd_parity_frame_rx.sv
// Directed bench for odd_parity_frame_rx: a default instance and an ERR_CNT_W=2
// instance share the same line stimulus so counter saturation is visible on the second.
module tb_odd_parity_frame_rx;

  logic       clk;
  logic       rst;
  logic       bit_valid;
  logic       rx_bit;

  logic [2:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
  logic [7:0] err_count;

  logic [2:0] data_out2;
  logic       data_valid2, parity_err2, frame_err2, busy2;
  logic [1:0] err_count2;

  int tests_run = 0;
  int tests_failed = 0;

  odd_parity_frame_rx #(.DATA_W(3), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .rx_bit(rx_bit),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  odd_parity_frame_rx #(.DATA_W(3), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .rx_bit(rx_bit),
    .data_out(data_out2), .data_valid(data_valid2), .parity_err(parity_err2),
    .frame_err(frame_err2), .busy(busy2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock edge with no strobe; sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bit_valid = 1'b1;
    rx_bit    = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    rx_bit    = 1'b1;
  endtask

  // frame bits are sent f[5] first: start, d0, d1, d2, parity, stop
  task automatic send_frame(input logic [5:0] f, input int gap);
    for (int i = 5; i >= 0; i--) begin
      strobe(f[i]);
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_busy", 32'(busy), 32'd1);
          chk("gap_no_dv", 32'(data_valid), 32'd0);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bit_valid = 1'b0;
    rx_bit    = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_pe", 32'(parity_err), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);

    // case 1: good frame, word 3'b101
    strobe(1'b0);
    chk("c1_busy_after_start", 32'(busy), 32'd1);
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    chk("c1_busy_in_stop", 32'(busy), 32'd1);
    strobe(1'b1);
    chk("c1_data_out", 32'(data_out), 32'h5);
    chk("c1_dv", 32'(data_valid), 32'd1);
    chk("c1_pe", 32'(parity_err), 32'd0);
    chk("c1_fe", 32'(frame_err), 32'd0);
    chk("c1_err", 32'(err_count), 32'd0);
    chk("c1_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("c1_dv_one_cycle", 32'(data_valid), 32'd0);

    // case 2: same word, parity bit 0 -> parity error, word still delivered
    send_frame(6'b010101, 0);
    chk("c2_data_out", 32'(data_out), 32'h5);
    chk("c2_dv", 32'(data_valid), 32'd1);
    chk("c2_pe", 32'(parity_err), 32'd1);
    chk("c2_err", 32'(err_count), 32'd1);
    tick();
    chk("c2_pe_one_cycle", 32'(parity_err), 32'd0);

    // case 3: stop bit 0 -> framing error, data_out keeps 3'b101
    send_frame(6'b001110, 0);
    chk("c3_fe", 32'(frame_err), 32'd1);
    chk("c3_dv", 32'(data_valid), 32'd0);
    chk("c3_pe", 32'(parity_err), 32'd0);
    chk("c3_data_out_held", 32'(data_out), 32'h5);
    chk("c3_err", 32'(err_count), 32'd2);
    chk("c3_err_w2", 32'(err_count2), 32'd2);
    tick();
    chk("c3_fe_one_cycle", 32'(frame_err), 32'd0);

    // case 4: idle strobes then the case-1 frame with 3 empty cycles between bits
    for (int k = 0; k < 5; k++) begin
      strobe(1'b1);
      chk("c4_idle_busy", 32'(busy), 32'd0);
      chk("c4_idle_dv", 32'(data_valid), 32'd0);
      chk("c4_idle_fe", 32'(frame_err), 32'd0);
    end
    send_frame(6'b010111, 3);
    chk("c4_data_out", 32'(data_out), 32'h5);
    chk("c4_dv", 32'(data_valid), 32'd1);
    chk("c4_pe", 32'(parity_err), 32'd0);
    chk("c4_err", 32'(err_count), 32'd2);

    // case 5: reset in mid-frame, then a good frame with word 3'b011
    tick();
    strobe(1'b0); strobe(1'b1); strobe(1'b0);
    chk("c5_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c5_busy", 32'(busy), 32'd0);
    chk("c5_dv", 32'(data_valid), 32'd0);
    chk("c5_pe", 32'(parity_err), 32'd0);
    chk("c5_fe", 32'(frame_err), 32'd0);
    chk("c5_err", 32'(err_count), 32'd0);
    chk("c5_data_out_rst", 32'(data_out), 32'd0);
    tick();
    chk("c5_no_late_pulse", 32'(data_valid | frame_err), 32'd0);
    send_frame(6'b011011, 0);
    chk("c5_data_out", 32'(data_out), 32'h3);
    chk("c5_dv2", 32'(data_valid), 32'd1);
    chk("c5_pe2", 32'(parity_err), 32'd0);

    // case 6: five bad-parity frames; 2-bit counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      send_frame(6'b010101, 0);
      chk("c6_pe_w2", 32'(parity_err2), 32'd1);
      chk("c6_err_w2", 32'(err_count2), (k < 3) ? 32'(k) : 32'd3);
      chk("c6_err_w8", 32'(err_count), 32'(k));
    end
    tick();
    chk("c6_err_w2_hold", 32'(err_count2), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
